weight_stream_loader: RTL

- Write-side feeder for the weight manager. Takes a 64-bit AXI-Stream of packed weight bytes from the DMA and regroups them into 72-bit words (9 bytes each).
- Drives the manager's wr_en / wr_data / wr_addr_rst port, one layer load per start command.
- Checks the stream length against the commanded word count and flags short or long streams.
- Sits between the host DMA and weight_manager in the layer-load path.

---
 rtl/weight_load_pkg.sv | 23 ++
 rtl/weight_gearbox_64to72.sv | 76 +++++++
 rtl/weight_stream_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/weight_load_pkg.sv
// Shared definitions for the weight layer-load path.
//   load_state_e : loader FSM states
//   BEAT_BYTES   : bytes per AXI-Stream beat
//   WORD_BYTES   : bytes per weight_manager word
//   BUF_BYTES    : gearbox buffer capacity in bytes
//   BUF_CNT_W    : width of the gearbox byte count (0..BUF_BYTES inclusive)
package weight_load_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    STREAM = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } load_state_e;

  localparam int BEAT_BYTES = 8;
  localparam int WORD_BYTES = 9;
  localparam int BUF_BYTES  = 16;
  localparam int BUF_CNT_W  = $clog2(BUF_BYTES + 1);

endpackage

// File: rtl/weight_gearbox_64to72.sv
// 64-bit to 72-bit byte regrouping buffer.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   clear      : drop all buffered bytes (and any push this cycle)
//   emit_en    : allow a word to leave the buffer this cycle
//   flush      : emit whatever is left (1..9 bytes), zero-padded above
//   push       : append push_data above the bytes that remain after any emit
//   push_data  : one beat, byte 0 in bits [7:0]
//   emit       : a word leaves the buffer this cycle
//   space_ok   : a beat fits this cycle (depends on registered state only)
//   cnt        : bytes currently held
//   wr_en      : registered write strobe, one cycle after emit
//   wr_data    : registered word, earliest byte in bits [7:0]
module weight_gearbox_64to72
  import weight_load_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    emit_en,
  input  logic                    flush,
  input  logic                    push,
  input  logic [BEAT_BYTES*8-1:0] push_data,
  output logic                    emit,
  output logic                    space_ok,
  output logic [BUF_CNT_W-1:0]    cnt,
  output logic                    wr_en,
  output logic [WORD_BYTES*8-1:0] wr_data
);

  localparam logic [BUF_CNT_W-1:0] WORD_CNT = BUF_CNT_W'(WORD_BYTES);
  localparam logic [BUF_CNT_W-1:0] BEAT_CNT = BUF_CNT_W'(BEAT_BYTES);

  // Bytes at or above cnt are kept at zero, so a flush word is padded for free.
  logic [BUF_BYTES*8-1:0] byte_buf;
  logic [BUF_BYTES*8-1:0] buf_shift;
  logic [BUF_BYTES*8-1:0] buf_fill;
  logic [BUF_CNT_W-1:0]   rem;

  always_comb begin
    emit = 1'b0;
    if (emit_en) emit = flush ? (cnt != '0) : (cnt >= WORD_CNT);
  end

  always_comb begin
    rem = cnt;
    if (emit) rem = (cnt >= WORD_CNT) ? (cnt - WORD_CNT) : '0;
    space_ok  = (rem <= BEAT_CNT);
    buf_shift = emit ? (byte_buf >> (WORD_BYTES*8)) : byte_buf;
    buf_fill  = buf_shift |
                ({{((BUF_BYTES-BEAT_BYTES)*8){1'b0}}, push_data} << {rem, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_buf <= '0;
      cnt      <= '0;
      wr_en    <= 1'b0;
      wr_data  <= '0;
    end else begin
      wr_en <= emit;
      if (emit) wr_data <= byte_buf[WORD_BYTES*8-1:0];
      if (clear) begin
        byte_buf <= '0;
        cnt      <= '0;
      end else if (push) begin
        byte_buf <= buf_fill;
        cnt      <= rem + BEAT_CNT;
      end else begin
        byte_buf <= buf_shift;
        cnt      <= rem;
      end
    end
  end

endmodule

// File: rtl/weight_stream_loader.sv
// Write-side feeder for weight_manager: regroups a 64-bit AXI-Stream of weight
// bytes into 72-bit words, one layer load per start, and checks stream length.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start/num_words : load command and word count N (sampled on start)
//   busy, done      : load in progress / one-cycle completion pulse
//   err_short/long  : sticky stream-length errors, cleared by the next start
//   words_written   : words emitted in the current load
//   s_axis_*        : weight byte stream from the DMA
//   wr_addr_rst     : pulse resetting the manager's write address
//   wr_en/wr_data   : write port into weight_manager
//
// state  | meaning
// IDLE   | waiting for start
// ADDR   | pulse wr_addr_rst; skip straight to DONE when N == 0
// STREAM | accept beats, emit words; padding beyond word N is discarded
// FLUSH  | stream ended early: emit leftovers, last word zero-padded
// DRAIN  | stream too long: swallow beats up to and including tlast
// DONE   | one-cycle done pulse
module weight_stream_loader
  import weight_load_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_W      = ADDR_WIDTH + 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_words,
  output logic                    busy,
  output logic                    done,
  output logic                    err_short,
  output logic                    err_long,
  output logic [CNT_W-1:0]        words_written,
  input  logic [BEAT_BYTES*8-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    wr_addr_rst,
  output logic                    wr_en,
  output logic [WORD_BYTES*8-1:0] wr_data
);

  // One extra bit so the beat count of any representable N cannot wrap.
  localparam int BEAT_W = CNT_W + 1;

  load_state_e          state;
  logic [CNT_W-1:0]     n_lat;
  logic [BEAT_W-1:0]    beats_exp;
  logic [BEAT_W-1:0]    beat_cnt;
  logic [BEAT_W-1:0]    beat_cnt_nxt;
  logic [BEAT_W+2:0]    bytes_req;
  logic                 unused_bytes_frac;
  logic                 last_ok;
  logic                 words_full;
  logic                 last_emit;
  logic                 accept;
  logic                 gb_clear;
  logic                 gb_emit_en;
  logic                 gb_flush;
  logic                 gb_push;
  logic                 gb_emit;
  logic                 gb_space_ok;
  logic [BUF_CNT_W-1:0] gb_cnt;

  // 9*N + 7; beats_exp is this divided by 8.
  assign bytes_req = {1'b0, num_words, 3'b000} + {4'b0000, num_words} + (BEAT_W+3)'(7);
  assign unused_bytes_frac = ^bytes_req[2:0];

  assign beat_cnt_nxt = beat_cnt + BEAT_W'(1);
  assign words_full   = (words_written == n_lat);
  assign last_emit    = gb_emit && ((words_written + CNT_W'(1)) == n_lat);

  assign s_axis_tready = ((state == STREAM) && gb_space_ok && (beat_cnt != beats_exp)) ||
                         (state == DRAIN);
  assign accept        = s_axis_tvalid && s_axis_tready;

  assign gb_push    = accept && (state == STREAM);
  assign gb_flush   = (state == FLUSH);
  assign gb_emit_en = ((state == STREAM) || (state == FLUSH) || (state == DRAIN)) && !words_full;
  // Once word N is out, everything else in this load is padding.
  assign gb_clear   = (state == IDLE) || ((state == STREAM) && (words_full || last_emit));

  weight_gearbox_64to72 u_gearbox (
    .clk       (clk),
    .rst       (rst),
    .clear     (gb_clear),
    .emit_en   (gb_emit_en),
    .flush     (gb_flush),
    .push      (gb_push),
    .push_data (s_axis_tdata),
    .emit      (gb_emit),
    .space_ok  (gb_space_ok),
    .cnt       (gb_cnt),
    .wr_en     (wr_en),
    .wr_data   (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      n_lat         <= '0;
      beats_exp     <= '0;
      beat_cnt      <= '0;
      last_ok       <= 1'b0;
      words_written <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err_short     <= 1'b0;
      err_long      <= 1'b0;
      wr_addr_rst   <= 1'b0;
    end else begin
      done        <= 1'b0;
      wr_addr_rst <= 1'b0;
      if (gb_emit) words_written <= words_written + CNT_W'(1);

      case (state)
        IDLE: begin
          if (start) begin
            n_lat         <= num_words;
            beats_exp     <= bytes_req[BEAT_W+2:3];
            beat_cnt      <= '0;
            last_ok       <= 1'b0;
            words_written <= '0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
            busy          <= 1'b1;
            wr_addr_rst   <= 1'b1;
            state         <= ADDR;
          end
        end

        ADDR: begin
          if (n_lat == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= STREAM;
          end
        end

        STREAM: begin
          if (accept) begin
            beat_cnt <= beat_cnt_nxt;
            if (beat_cnt_nxt == beats_exp) begin
              if (s_axis_tlast) begin
                last_ok <= 1'b1;
              end else begin
                err_long <= 1'b1;
                state    <= DRAIN;
              end
            end else if (s_axis_tlast) begin
              err_short <= 1'b1;
              state     <= FLUSH;
            end
          end else if (words_full && last_ok) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        FLUSH: begin
          if (gb_cnt == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        // The buffer holds at most one outstanding word on entry; it is
        // emitted in the first DRAIN cycle, before any tlast can end the load.
        DRAIN: begin
          if (accept && s_axis_tlast) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
